dom_pwr_seq: RTL and testbench
==============================

# dom_pwr_seq

Clock/reset sequencer for the SoC clock domains (e_core, p_core, core link, system link, peripheral link). It sits between the system control register file and the clock/reset generator. It turns per-domain software on/off requests into ordered sequences of PLL-lock wait, clock-enable and reset-release/assert. One domain is sequenced at a time, so no two domains ever change clock or reset state in the same cycle.

## Interface

Parameters:
- `NUM_DOM`, default 5: number of sequenced domains; index 0 is highest priority.
- `LOCK_TIMEOUT`, default 1024: maximum WAIT_LOCK cycles before the lock attempt is declared failed.
- `CLK_SETTLE`, default 8: cycles the clock runs with reset held before reset release.
- `RST_SETTLE`, default 4: cycles the clock runs with reset asserted before the clock is gated.

Ports:
- `clk_i`, in, 1: sequencer clock.
- `arst_i`, in, 1: reset, asynchronous, active-high.
- `dom_req_i`, in, `NUM_DOM`: requested domain state (1 = on).
- `pll_locked_i`, in, `NUM_DOM`: per-domain PLL lock; tie to 1 for domains without a PLL.
- `timeout_clr_i`, in, `NUM_DOM`: single-cycle clear of `timeout_o` bits.
- `clk_en_o`, out, `NUM_DOM`: domain clock enable to the clock/reset generator.
- `rst_no`, out, `NUM_DOM`: domain reset request, active-low.
- `dom_on_o`, out, `NUM_DOM`: domain is clocked and out of reset.
- `timeout_o`, out, `NUM_DOM`: sticky lock-timeout flag.
- `busy_o`, out, 1: a sequence is in progress (state is not IDLE).
- `cur_dom_o`, out, `$clog2(NUM_DOM)`: index of the domain being sequenced; holds its last value in IDLE.

## Operation

- All outputs are registered. Reset value of every output is 0; the state resets to IDLE and the counter to 0.
- States: IDLE, WAIT_LOCK, CLK_SETTLE, RST_SETTLE.
- **Selection in IDLE**, using sampled `dom_req_i` and `dom_on_o`:
  - Power-down candidates are domains with `dom_on_o`=1 and `dom_req_i`=0.
  - Power-up candidates are domains with `dom_on_o`=0, `dom_req_i`=1 and `timeout_o`=0.
  - Any power-down candidate beats any power-up candidate. Within each class, the lowest index wins.
  - The selected index is latched into `cur_dom_o`.
- **Up path:**
  - IDLE → WAIT_LOCK; counter cleared.
  - In WAIT_LOCK, `pll_locked_i[d]` sampled high on two consecutive cycles → CLK_SETTLE. On entry, `clk_en_o[d]`=1 and `rst_no[d]` stays 0.
  - CLK_SETTLE counts `CLK_SETTLE` cycles. It then sets `rst_no[d]`=1 and `dom_on_o[d]`=1 and returns to IDLE.
- **Lock timeout:** the counter reaching `LOCK_TIMEOUT` in WAIT_LOCK sets `timeout_o[d]` and returns to IDLE. No clock or reset outputs change. The domain is not retried until `timeout_o[d]` is cleared.
- **Down path:**
  - IDLE → RST_SETTLE. On entry, `rst_no[d]`=0 and `dom_on_o[d]`=0; the clock keeps running.
  - After `RST_SETTLE` cycles, `clk_en_o[d]`=0 → IDLE.
- **Request withdrawn mid-sequence** (`dom_req_i[d]` goes to 0):
  - In WAIT_LOCK: abort to IDLE; no output changes; counter cleared.
  - In CLK_SETTLE: go to RST_SETTLE. The counter restarts and the normal down completion follows, ending with `clk_en_o[d]`=0.
- **Lock lost in CLK_SETTLE:** no effect; the sequence completes.
- **Requests for other domains** during a sequence are ignored until IDLE.
- `timeout_clr_i[d]` and a timeout set for the same d in the same cycle: set wins.
- The counter width is sized for max(`LOCK_TIMEOUT`, `CLK_SETTLE`, `RST_SETTLE`). It saturates and never wraps.
- **`arst_i` mid-sequence:** all outputs immediately go to 0, so every domain is gated and held in reset. After reset is released, domains are re-sequenced from requests.

## Timing

- Cycle 0 is the first clock edge at which a changed request is sampled in IDLE.
- Up latency with PLL already locked:
  - WAIT_LOCK at edge 1; lock sampled at edges 1 and 2.
  - `clk_en_o` high after edge 3.
  - `rst_no` and `dom_on_o` high after edge 3+`CLK_SETTLE` (edge 11 with defaults).
  - `busy_o` falls on the same edge.
- Down latency:
  - `rst_no` and `dom_on_o` low after edge 1.
  - `clk_en_o` low after edge 1+`RST_SETTLE` (edge 5 with defaults).
- Timeout fires after edge 1+`LOCK_TIMEOUT`.
- At least one IDLE cycle separates consecutive sequences.

## Test plan

- Domain 2 requested, PLL locked → `clk_en_o[2]` rises at edge 3, `rst_no[2]`/`dom_on_o[2]` rise at edge 11, no other bits change.
- Domains 0 and 3 requested in the same cycle → domain 0 completes (`dom_on_o` at edge 11), one IDLE cycle follows, then domain 3 `dom_on_o` rises at edge 23.
- Domain 1 on, drop its request while domain 4 is requested → domain 1 goes down first (`rst_no[1]`=0 at edge 1, `clk_en_o[1]`=0 at edge 5), then domain 4 comes up.
- `pll_locked_i[0]` held 0 → `timeout_o[0]` set after edge 1025, clocks stay off, no retry. After `timeout_clr_i[0]` with lock high, domain 0 comes up.
- Request dropped at CLK_SETTLE cycle 3 → `rst_no` stays 0, `dom_on_o` stays 0, `clk_en_o` falls 4 cycles later.
- `arst_i` pulsed mid-CLK_SETTLE with 2 domains on → all outputs 0 immediately. After release, both domains re-sequence in index order.

Source files
------------

// File: rtl/dom_pwr_seq.sv
// Clock/reset sequencer for SoC clock domains: walks one domain at a time
// through PLL-lock wait, clock enable, reset release (up) or the reverse (down).
module dom_pwr_seq #(
  parameter int NUM_DOM      = 5,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int CLK_SETTLE   = 8,
  parameter int RST_SETTLE   = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic [NUM_DOM-1:0]         dom_req_i,
  input  logic [NUM_DOM-1:0]         pll_locked_i,
  input  logic [NUM_DOM-1:0]         timeout_clr_i,
  output logic [NUM_DOM-1:0]         clk_en_o,
  output logic [NUM_DOM-1:0]         rst_no,
  output logic [NUM_DOM-1:0]         dom_on_o,
  output logic [NUM_DOM-1:0]         timeout_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_DOM)-1:0] cur_dom_o,
  output logic [1:0]                 dbg_state_o
);

  localparam int IW   = $clog2(NUM_DOM);
  localparam int MAXC = (LOCK_TIMEOUT > CLK_SETTLE)
                        ? ((LOCK_TIMEOUT > RST_SETTLE) ? LOCK_TIMEOUT : RST_SETTLE)
                        : ((CLK_SETTLE > RST_SETTLE) ? CLK_SETTLE : RST_SETTLE);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_LOCK  = 2'd1,
    S_CLK_SETTLE = 2'd2,
    S_RST_SETTLE = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt, cnt_inc;
  logic                lock_seen, lock_seen_nxt;
  logic                sel_vld, sel_vld_nxt, sel_up, sel_up_nxt;
  logic [IW-1:0]       cur_dom_nxt;
  logic [NUM_DOM-1:0]  pll_q;
  logic                dn_hit, up_hit;
  logic [IW-1:0]       dn_idx, up_idx;
  logic                ev_clk_on, ev_clk_off, ev_rst_rel, ev_rst_asrt, ev_timeout;
  logic [NUM_DOM-1:0]  clk_en_nxt, rst_n_nxt, dom_on_nxt, timeout_nxt;

  // Request semantics: dom_req_i is a level; dom_on_o is the matching level
  // acknowledge. A domain is serviced when request and acknowledge disagree.
  assign cnt_inc     = (&cnt) ? cnt : cnt + CW'(1);
  assign dbg_state_o = state;

  always_comb begin
    dn_hit = 1'b0;
    up_hit = 1'b0;
    dn_idx = '0;
    up_idx = '0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (dom_on_o[i] && !dom_req_i[i]) begin
        dn_hit = 1'b1;
        dn_idx = IW'(i);
      end
      if (!dom_on_o[i] && dom_req_i[i] && !timeout_o[i]) begin
        up_hit = 1'b1;
        up_idx = IW'(i);
      end
    end
  end

  // Next state. IDLE spends one cycle latching the selection before launching it.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt_inc;
    lock_seen_nxt = lock_seen;
    sel_vld_nxt   = sel_vld;
    sel_up_nxt    = sel_up;
    cur_dom_nxt   = cur_dom_o;
    ev_clk_on     = 1'b0;
    ev_clk_off    = 1'b0;
    ev_rst_rel    = 1'b0;
    ev_rst_asrt   = 1'b0;
    ev_timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt       = '0;
        lock_seen_nxt = 1'b0;
        if (sel_vld) begin
          sel_vld_nxt = 1'b0;
          if (sel_up && dom_req_i[cur_dom_o]) begin
            state_nxt = S_WAIT_LOCK;
          end else if (!sel_up && !dom_req_i[cur_dom_o]) begin
            state_nxt   = S_RST_SETTLE;
            ev_rst_asrt = 1'b1;
          end
        end else if (dn_hit) begin
          sel_vld_nxt = 1'b1;
          sel_up_nxt  = 1'b0;
          cur_dom_nxt = dn_idx;
        end else if (up_hit) begin
          sel_vld_nxt = 1'b1;
          sel_up_nxt  = 1'b1;
          cur_dom_nxt = up_idx;
        end
      end
      S_WAIT_LOCK: begin
        if (!dom_req_i[cur_dom_o]) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (lock_seen && pll_q[cur_dom_o]) begin
          state_nxt = S_CLK_SETTLE;
          cnt_nxt   = '0;
          ev_clk_on = 1'b1;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state_nxt  = S_IDLE;
          cnt_nxt    = '0;
          ev_timeout = 1'b1;
        end else begin
          lock_seen_nxt = pll_q[cur_dom_o];
        end
      end
      S_CLK_SETTLE: begin
        if (!dom_req_i[cur_dom_o]) begin
          state_nxt   = S_RST_SETTLE;
          cnt_nxt     = '0;
          ev_rst_asrt = 1'b1;
        end else if (cnt == CW'(CLK_SETTLE - 1)) begin
          state_nxt  = S_IDLE;
          ev_rst_rel = 1'b1;
        end
      end
      S_RST_SETTLE: begin
        if (cnt == CW'(RST_SETTLE - 1)) begin
          state_nxt  = S_IDLE;
          ev_clk_off = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output next values; timeout set takes precedence over a same-cycle clear.
  always_comb begin
    clk_en_nxt  = clk_en_o;
    rst_n_nxt   = rst_no;
    dom_on_nxt  = dom_on_o;
    timeout_nxt = timeout_o & ~timeout_clr_i;
    if (ev_clk_on)   clk_en_nxt[cur_dom_o]  = 1'b1;
    if (ev_clk_off)  clk_en_nxt[cur_dom_o]  = 1'b0;
    if (ev_rst_rel) begin
      rst_n_nxt[cur_dom_o]  = 1'b1;
      dom_on_nxt[cur_dom_o] = 1'b1;
    end
    if (ev_rst_asrt) begin
      rst_n_nxt[cur_dom_o]  = 1'b0;
      dom_on_nxt[cur_dom_o] = 1'b0;
    end
    if (ev_timeout)  timeout_nxt[cur_dom_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lock_seen <= 1'b0;
      sel_vld   <= 1'b0;
      sel_up    <= 1'b0;
      pll_q     <= '0;
      cur_dom_o <= '0;
      clk_en_o  <= '0;
      rst_no    <= '0;
      dom_on_o  <= '0;
      timeout_o <= '0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lock_seen <= lock_seen_nxt;
      sel_vld   <= sel_vld_nxt;
      sel_up    <= sel_up_nxt;
      pll_q     <= pll_locked_i;
      cur_dom_o <= cur_dom_nxt;
      clk_en_o  <= clk_en_nxt;
      rst_no    <= rst_n_nxt;
      dom_on_o  <= dom_on_nxt;
      timeout_o <= timeout_nxt;
      busy_o    <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_dom_pwr_seq.sv
// Directed bench for dom_pwr_seq: up/down/priority/timeout/withdraw/reset cases
// with cycle-exact expected values.
module tb_dom_pwr_seq;

  logic       clk;
  logic       arst;
  logic [4:0] dom_req;
  logic [4:0] pll_locked;
  logic [4:0] timeout_clr;
  logic [4:0] clk_en;
  logic [4:0] rst_n;
  logic [4:0] dom_on;
  logic [4:0] timeout;
  logic       busy;
  logic [2:0] cur_dom;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  dom_pwr_seq dut (
    .clk_i         (clk),
    .arst_i        (arst),
    .dom_req_i     (dom_req),
    .pll_locked_i  (pll_locked),
    .timeout_clr_i (timeout_clr),
    .clk_en_o      (clk_en),
    .rst_no        (rst_n),
    .dom_on_o      (dom_on),
    .timeout_o     (timeout),
    .busy_o        (busy),
    .cur_dom_o     (cur_dom),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clk_en"},  32'(clk_en),  0);
    check({tag, "_rst_n"},   32'(rst_n),   0);
    check({tag, "_dom_on"},  32'(dom_on),  0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_busy"},    32'(busy),    0);
    check({tag, "_cur_dom"}, 32'(cur_dom), 0);
  endtask

  initial begin
    arst        = 1'b1;
    dom_req     = '0;
    pll_locked  = 5'b11111;
    timeout_clr = '0;
    tick(2);
    check_all_zero("reset");
    check("reset_state", 32'(dbg_state), 0);
    arst = 1'b0;
    tick(3);

    // domain 2 up with PLL already locked
    dom_req = 5'b00100;
    tick(1);  check("t1_e0_busy", 32'(busy), 0);
    tick(1);  check("t1_e1_busy", 32'(busy), 1);
              check("t1_e1_cur", 32'(cur_dom), 2);
    tick(1);  check("t1_e2_clk_en", 32'(clk_en), 0);
    tick(1);  check("t1_e3_clk_en", 32'(clk_en), 5'b00100);
              check("t1_e3_rst_n", 32'(rst_n), 0);
    tick(7);  check("t1_e10_dom_on", 32'(dom_on), 0);
              check("t1_e10_busy", 32'(busy), 1);
    tick(1);  check("t1_e11_dom_on", 32'(dom_on), 5'b00100);
              check("t1_e11_rst_n", 32'(rst_n), 5'b00100);
              check("t1_e11_busy", 32'(busy), 0);
              check("t1_e11_clk_en", 32'(clk_en), 5'b00100);

    // domains 0 and 3 together: lowest index first, then one gap cycle
    dom_req = 5'b01101;
    tick(12); check("t2_e11_dom_on", 32'(dom_on), 5'b00101);
              check("t2_e11_busy", 32'(busy), 0);
              check("t2_e11_cur", 32'(cur_dom), 0);
    tick(1);  check("t2_e12_busy", 32'(busy), 0);
              check("t2_e12_cur", 32'(cur_dom), 3);
    tick(1);  check("t2_e13_busy", 32'(busy), 1);
    tick(2);  check("t2_e15_clk_en", 32'(clk_en), 5'b01101);
    tick(7);  check("t2_e22_dom_on", 32'(dom_on), 5'b00101);
    tick(1);  check("t2_e23_dom_on", 32'(dom_on), 5'b01101);
              check("t2_e23_rst_n", 32'(rst_n), 5'b01101);

    // domain 1 on, then drop it while requesting 4: down wins
    dom_req = 5'b01111;
    tick(12); check("t3_pre_dom_on", 32'(dom_on), 5'b01111);
    dom_req = 5'b11101;
    tick(2);  check("t3_e1_rst_n", 32'(rst_n), 5'b01101);
              check("t3_e1_dom_on", 32'(dom_on), 5'b01101);
              check("t3_e1_cur", 32'(cur_dom), 1);
    tick(3);  check("t3_e4_clk_en", 32'(clk_en), 5'b01111);
    tick(1);  check("t3_e5_clk_en", 32'(clk_en), 5'b01101);
              check("t3_e5_busy", 32'(busy), 0);
    tick(4);  check("t3_e9_clk_en", 32'(clk_en), 5'b11101);
              check("t3_e9_cur", 32'(cur_dom), 4);
    tick(7);  check("t3_e16_dom_on", 32'(dom_on), 5'b01101);
    tick(1);  check("t3_e17_dom_on", 32'(dom_on), 5'b11101);

    // domain 0 down, then lock timeout, no retry, clear and retry
    dom_req = 5'b11100;
    tick(8);  check("t4_down_dom_on", 32'(dom_on), 5'b11100);
              check("t4_down_clk_en", 32'(clk_en), 5'b11100);
    pll_locked = 5'b11110;
    dom_req    = 5'b11101;
    tick(1025); check("t4_e1024_timeout", 32'(timeout), 0);
                check("t4_e1024_busy", 32'(busy), 1);
    tick(1);  check("t4_e1025_timeout", 32'(timeout), 5'b00001);
              check("t4_e1025_busy", 32'(busy), 0);
              check("t4_e1025_clk_en", 32'(clk_en), 5'b11100);
              check("t4_e1025_rst_n", 32'(rst_n), 5'b11100);
    tick(10); check("t4_noretry_busy", 32'(busy), 0);
              check("t4_noretry_timeout", 32'(timeout), 5'b00001);
              check("t4_noretry_dom_on", 32'(dom_on), 5'b11100);
    pll_locked  = 5'b11111;
    timeout_clr = 5'b00001;
    tick(1);  check("t4_clr_timeout", 32'(timeout), 0);
    timeout_clr = 5'b00000;
    tick(4);  check("t4_retry_clk_en", 32'(clk_en), 5'b11101);
    tick(7);  check("t4_retry_e11_dom_on", 32'(dom_on), 5'b11100);
    tick(1);  check("t4_retry_e12_dom_on", 32'(dom_on), 5'b11101);

    // domain 1 withdrawn during CLK_SETTLE
    dom_req = 5'b11111;
    tick(4);  check("t5_e3_clk_en", 32'(clk_en), 5'b11111);
              check("t5_e3_cur", 32'(cur_dom), 1);
    tick(2);
    dom_req = 5'b11101;
    tick(4);  check("t5_e9_clk_en", 32'(clk_en), 5'b11111);
              check("t5_e9_rst_n", 32'(rst_n), 5'b11101);
              check("t5_e9_dom_on", 32'(dom_on), 5'b11101);
              check("t5_e9_busy", 32'(busy), 1);
    tick(1);  check("t5_e10_clk_en", 32'(clk_en), 5'b11101);
              check("t5_e10_busy", 32'(busy), 0);
    tick(1);  check("t5_e11_rst_n", 32'(rst_n), 5'b11101);

    // asynchronous reset clears everything immediately
    dom_req = 5'b00000;
    arst    = 1'b1;
    #1;
    check_all_zero("t6_arst_a");
    tick(1);
    arst    = 1'b0;
    dom_req = 5'b00011;
    tick(24); check("t6_two_on", 32'(dom_on), 5'b00011);
    dom_req = 5'b00111;
    tick(6);  check("t6_e5_clk_en", 32'(clk_en), 5'b00111);
              check("t6_e5_busy", 32'(busy), 1);
    arst = 1'b1;
    #1;
    check_all_zero("t6_arst_b");
    tick(1);
    arst = 1'b0;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00011);
    exp_q.push_back(5'b00111);
    for (int i = 0; i < 3; i++) begin
      tick(12);
      check($sformatf("t6_reseq_%0d", i), 32'(dom_on), 32'(exp_q.pop_front()));
    end
    check("t6_final_clk_en", 32'(clk_en), 5'b00111);
    check("t6_final_rst_n", 32'(rst_n), 5'b00111);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
